// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI (mode 0) slave giving an MCU access to a small
// register file (LED, analog mux select, scratch, status).
//
// Parameter:
//   SYNC_STAGES - synchronizer depth on sclk, cs and mosi
// Ports:
//   clk        - system clock (XTALCLK), the only clock in the block
//   rst_n      - asynchronous active-low reset
//   sclk       - SPI clock from the MCU
//   cs         - SPI chip select, active low
//   mosi       - SPI data in
//   miso       - SPI data out, always driven
//   reg_led    - LED register, bits [1:0] drive LED1/LED2
//   reg_mux    - analog mux select register
//   wr_strobe  - one-clk pulse per committed write
//   frame_err  - sticky frame-error flag
//
// Frame (MSB first, 16 bits): {rw, addr[6:0], data[7:0]}, rw = 1 is a write.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a cs falling edge
// S_ADDR  | shifting in rw + address (rising edges 1-8)
// S_DATA  | shifting data in, read data out on miso (rising edges 9-16)
// S_DONE  | full frame received, waiting for cs high
// S_ABORT | after reset: discard any frame in progress until cs is high

module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] reg_led,
  output logic [7:0] reg_mux,
  output logic       wr_strobe,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_ABORT
  } state_t;

  // Settle time after reset: the synchronizers come out of reset holding
  // the idle pattern, so cs is not trusted until the real pin level has
  // propagated through them and the edge-detect flop.
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;
  logic [SW-1:0]          settle_q;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  rd_shift_q, rd_shift_d;
  logic        miso_q, miso_d;
  logic        commit_q, commit_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        err_set;

  logic [7:0]  led_q, mux_q, scratch_q;
  logic        err_q, wr_strobe_q;

  logic [6:0]  addr_nxt;
  logic [7:0]  rd_data;

  // Synchronizers plus one extra delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      settle_q    <= SETTLE_INIT;
    end else begin
      sclk_sync_q[0] <= sclk;
      cs_sync_q[0]   <= cs;
      mosi_sync_q[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      sclk_dly_q <= sclk_s;
      cs_dly_q   <= cs_s;
      if (settle_q != '0) settle_q <= settle_q - SW'(1);
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  // Address as it will be after the 8th rising edge; used to preload read data.
  assign addr_nxt = {shift_q[5:0], mosi_s};

  always_comb begin
    rd_data = 8'h00;
    case (addr_nxt)
      7'h00:   rd_data = led_q;
      7'h01:   rd_data = mux_q;
      7'h02:   rd_data = scratch_q;
      7'h03:   rd_data = {7'b0, err_q};
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    rd_shift_d = rd_shift_q;
    miso_d     = 1'b0;
    commit_d   = 1'b0;
    wdata_d    = wdata_q;
    err_set    = 1'b0;

    case (state_q)
      S_ABORT: begin
        cnt_d = 5'd0;
        if (settle_q == '0 && cs_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = 5'd0;
        if (cs_fall) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (cs_s) begin
          state_d = S_IDLE;
          if (cnt_q != 5'd0) err_set = 1'b1;
        end else if (sclk_rise) begin
          shift_d = {shift_q[5:0], mosi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            state_d = S_DATA;
            rw_d    = shift_q[6];
            addr_d  = addr_nxt;
            if (!shift_q[6]) rd_shift_d = rd_data;
          end
        end
      end
      S_DATA: begin
        miso_d = miso_q;
        if (cs_s) begin
          state_d = S_IDLE;
          err_set = 1'b1;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          shift_d = {shift_q[5:0], mosi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_d  = S_DONE;
            miso_d   = 1'b0;
            commit_d = rw_q && (addr_q < 7'd4);
            wdata_d  = {shift_q, mosi_s};
          end
        end else if (sclk_fall && !rw_q) begin
          miso_d     = rd_shift_q[7];
          rd_shift_d = {rd_shift_q[6:0], 1'b0};
        end
      end
      S_DONE: begin
        if (sclk_rise) err_set = 1'b1;
        if (cs_s) state_d = S_IDLE;
      end
      default: state_d = S_ABORT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ABORT;
      cnt_q      <= 5'd0;
      shift_q    <= 7'd0;
      rw_q       <= 1'b0;
      addr_q     <= 7'd0;
      rd_shift_q <= 8'd0;
      miso_q     <= 1'b0;
      commit_q   <= 1'b0;
      wdata_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      rd_shift_q <= rd_shift_d;
      miso_q     <= miso_d;
      commit_q   <= commit_d;
      wdata_q    <= wdata_d;
    end
  end

  // Register file: the write lands one clk after the frame completes.
  // A frame-error set outranks a status clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q       <= 8'h00;
      mux_q       <= 8'h00;
      scratch_q   <= 8'hA5;
      err_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
    end else begin
      wr_strobe_q <= commit_q;
      if (commit_q) begin
        case (addr_q)
          7'h00:   led_q     <= wdata_q;
          7'h01:   mux_q     <= wdata_q;
          7'h02:   scratch_q <= wdata_q;
          default: ;
        endcase
      end
      if (err_set)
        err_q <= 1'b1;
      else if (commit_q && addr_q == 7'h03 && wdata_q[0])
        err_q <= 1'b0;
    end
  end

  assign miso      = miso_q;
  assign reg_led   = led_q;
  assign reg_mux   = mux_q;
  assign wr_strobe = wr_strobe_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed and randomized SPI frames, with a
// register-map reference model feeding expected write/read results into
// queues that independent monitors pop and compare.

module tb_spi_reg_ctrl;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] reg_led, reg_mux;
  logic       wr_strobe, frame_err;

  spi_reg_ctrl #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .reg_led   (reg_led),
    .reg_mux   (reg_mux),
    .wr_strobe (wr_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] led;
    logic [7:0] mux;
    logic       err;
  } wr_exp_t;

  wr_exp_t    wr_q[$];
  logic [7:0] rd_q[$];

  logic [7:0] m_mem[3];
  logic       m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mem[0] = 8'h00;
    m_mem[1] = 8'h00;
    m_mem[2] = 8'hA5;
    m_err    = 1'b0;
  endtask

  // Reference model: effect of a frame of n rising edges carrying word w.
  task automatic model_apply(input logic [15:0] w, input int n);
    logic       rw;
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] rv;
    rw = w[15];
    a  = w[14:8];
    d  = w[7:0];
    if (n == 0) return;
    if (n < 16) begin
      m_err = 1'b1;
      return;
    end
    if (rw) begin
      if (a < 3) m_mem[a[1:0]] = d;
      if (a == 3 && d[0]) m_err = 1'b0;
      if (a < 4) wr_q.push_back('{m_mem[0], m_mem[1], m_err});
    end else if (n == 16) begin
      if (a < 3)       rv = m_mem[a[1:0]];
      else if (a == 3) rv = {7'b0, m_err};
      else             rv = 8'h00;
      rd_q.push_back(rv);
    end
    if (n > 16) m_err = 1'b1;
  endtask

  // Write-strobe monitor: each pulse pops one expected write.
  int strobe_run = 0;
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_run++;
      if (strobe_run == 1) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wr_strobe actual=1 required=0");
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("wr_reg_led", reg_led, e.led);
          check("wr_reg_mux", reg_mux, e.mux);
          check("wr_frame_err", frame_err, e.err);
        end
      end else begin
        check("wr_strobe_width", strobe_run, 1);
      end
    end else begin
      strobe_run = 0;
    end
  end

  // SPI monitor: master-side view, sampling on sclk rising edges.
  int          nb = 0;
  logic [15:0] mon_mosi = '0;
  logic [15:0] mon_miso = '0;

  always @(negedge cs) nb = 0;

  always @(posedge sclk) begin
    if (!cs) begin
      if (nb < 16) begin
        mon_mosi[15-nb] = mosi;
        mon_miso[15-nb] = miso;
      end
      nb++;
    end
  end

  always @(posedge cs) begin
    if (nb == 16) begin
      check("miso_addr_phase", mon_miso[15:8], 8'h00);
      if (!mon_mosi[15]) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL read_no_expectation actual=0x%0h required=none", mon_miso[7:0]);
        end else begin
          logic [7:0] exp_rd;
          exp_rd = rd_q.pop_front();
          check("read_data", mon_miso[7:0], exp_rd);
        end
      end else begin
        check("miso_write_frame", mon_miso[7:0], 8'h00);
      end
    end
  end

  task automatic send_bits(input logic [15:0] w, input int from, input int to);
    for (int i = from; i < to; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [15:0] w, input int n);
    model_apply(w, n);
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(w, 0, n);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
    check("frame_err_after_frame", frame_err, m_err);
    check("miso_idle", miso, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [6:0]  a;
    int          n;

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_reg_led", reg_led, 8'h00);
    check("rst_reg_mux", reg_mux, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_miso", miso, 1'b0);
    repeat (10) @(negedge clk);

    // Read scratch reset value, then LED write.
    spi_frame(16'h0200, 16);
    spi_frame(16'h8003, 16);
    check("led_bits", reg_led[1:0], 2'b11);

    // Truncated write, status read, status clear.
    spi_frame(16'h81FF, 11);
    check("truncated_mux", reg_mux, 8'h00);
    spi_frame(16'h0300, 16);
    spi_frame(16'h8301, 16);

    // Over-long write.
    spi_frame(16'h8155, 17);
    check("overlong_mux", reg_mux, 8'h55);
    spi_frame(16'h8301, 16);

    // Reset pulsed mid-frame with cs held low.
    w = 16'h8133;
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(w, 0, 6);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_bits(w, 6, 16);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_reg_led", reg_led, 8'h00);
    check("midrst_reg_mux", reg_mux, 8'h00);
    check("midrst_frame_err", frame_err, 1'b0);
    spi_frame(16'h0200, 16);
    spi_frame(16'h8122, 16);
    check("after_midrst_mux", reg_mux, 8'h22);

    // Unmapped address write and read.
    spi_frame(16'hFF12, 16);
    spi_frame(16'h7F00, 16);
    spi_frame(16'h0000, 16);
    spi_frame(16'h0100, 16);

    // Randomized frames.
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 5);
      if (n < 4) a = 7'(n);
      else       a = 7'($urandom_range(4, 127));
      w = {1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 9) < 8) n = 16;
      else                          n = $urandom_range(0, 17);
      spi_frame(w, n);
    end
    spi_frame(16'h0200, 16);
    spi_frame(16'h0300, 16);

    repeat (10) @(negedge clk);
    check("final_reg_led", reg_led, m_mem[0]);
    check("final_reg_mux", reg_mux, m_mem[1]);
    check("final_frame_err", frame_err, m_err);
    check("wr_queue_empty", wr_q.size(), 0);
    check("rd_queue_empty", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
